y_drain: RTL and testbench
==========================

Y_DRAIN -- requirements
Module: y_drain

Interface
REQ-001 The module SHALL have parameter DW, default 16, giving the FP16 element width.
REQ-002 The module SHALL have parameter H_TILE, default 1, giving the head tile size.
REQ-003 The module SHALL have parameter P_TILE, default 1, giving the p tile size. N = H_TILE*P_TILE.
REQ-004 The module SHALL have parameter DEPTH, default 4, giving the vector FIFO depth. DEPTH shall be a power of 2 and at least 2.
REQ-005 The module SHALL use LW = max(1, clog2(N)) and CW = clog2(DEPTH)+1 as derived widths.
REQ-006 The module SHALL have input clk, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 The module SHALL have input rstn, 1 bit, an asynchronous active-low reset.
REQ-008 The module SHALL have input valid_i, 1 bit, marking y_i as valid for one cycle; there is no backpressure toward the source.
REQ-009 The module SHALL have input y_i, N*DW bits, the (h*p) vector; lane k occupies bits DW*(k+1)-1 down to DW*k.
REQ-010 The module SHALL have output m_valid_o, 1 bit, the output stream valid.
REQ-011 The module SHALL have input m_ready_i, 1 bit, the output stream ready.
REQ-012 The module SHALL have output m_data_o, DW bits, the current lane element.
REQ-013 The module SHALL have output m_lane_o, LW bits, the lane index of m_data_o.
REQ-014 The module SHALL have output m_last_o, 1 bit, high on the final lane (N-1) of a vector.
REQ-015 The module SHALL have output count_o, CW bits, the number of vectors stored, partially drained vectors included.
REQ-016 The module SHALL have output full_o, 1 bit, asserted when count_o == DEPTH.
REQ-017 The module SHALL have output ovf_o, 1 bit, a sticky flag for a dropped input vector.
REQ-018 The module SHALL have input clr_ovf_i, 1 bit, a synchronous clear for ovf_o.

Function
REQ-019 Fire SHALL be defined as m_valid_o && m_ready_i; pop SHALL be defined as fire && (lane_cnt == N-1).
REQ-020 Write: on valid_i && (!full_o || pop), y_i SHALL be stored at the tail in the same edge. A full FIFO with a same-cycle pop accepts the write, and count_o stays DEPTH.
REQ-021 Drop: on valid_i && full_o && !pop, y_i SHALL be discarded and ovf_o set to 1 at that edge.
REQ-022 ovf_o SHALL clear only on clr_ovf_i or reset. If clr_ovf_i and a drop occur in the same cycle, ovf_o SHALL be 1.
REQ-023 m_valid_o SHALL equal (count_o != 0). A vector written at edge k SHALL be visible on m_valid_o after edge k, giving 1-cycle latency with no combinational valid_i-to-m_valid_o path.
REQ-024 m_data_o SHALL be lane lane_cnt of the head vector, with m_lane_o = lane_cnt and m_last_o = (lane_cnt == N-1).
REQ-025 Lanes SHALL drain in ascending order, 0 to N-1.
REQ-026 On fire with lane_cnt < N-1, lane_cnt SHALL increment. On pop, lane_cnt SHALL return to 0 and the head SHALL advance.
REQ-027 While m_valid_o && !m_ready_i, m_data_o, m_lane_o and m_last_o SHALL hold stable. m_valid_o SHALL never deassert without a fire.
REQ-028 count_o SHALL evolve as count_o + write - pop. Pointers SHALL wrap modulo DEPTH.
REQ-029 With N == 1, every fire SHALL be a pop, m_last_o SHALL be 1 whenever m_valid_o is high, and m_lane_o SHALL be 0.
REQ-030 Empty FIFO with m_ready_i high and no write: no fire, and all state SHALL hold.
REQ-031 Sustained throughput SHALL be one element per cycle. One vector per N cycles SHALL be sustainable without drops.

Reset
REQ-032 While rstn is low, m_valid_o, m_last_o, m_lane_o, count_o, full_o and ovf_o SHALL be 0, lane_cnt and pointers 0, and m_data_o 0.
REQ-033 Reset mid-vector SHALL discard all stored and partially drained vectors. No beats SHALL appear after release until a new valid_i.
REQ-034 FIFO storage contents SHALL not require reset, but m_data_o SHALL be forced to 0 while count_o == 0.

Verification (H_TILE=2, P_TILE=2, DW=16, DEPTH=4)
REQ-035 Reset check: assert rstn low mid-stream -> all outputs 0 immediately (asynchronously), and count_o=0 after release.
REQ-036 Single vector: y_i={4400,4200,4000,3C00} (hex), 1 cycle, m_ready_i=1 -> m_valid_o on the next cycle, then beats 3C00/0, 4000/1, 4200/2, 4400/3 on consecutive cycles, m_last_o only on the 4th beat, then count_o=0.
REQ-037 Backpressure: toggle m_ready_i 1,0,0,1,... during a vector -> each element is presented exactly once, stalled beats are held stable, and order is lanes 0..3.
REQ-038 Overflow: m_ready_i=0, 5 consecutive valid_i with vectors V0..V4 -> count_o=4, full_o=1, ovf_o=1 after the 5th edge; then m_ready_i=1 -> 16 beats of V0..V3, V4 never appears; clr_ovf_i pulse -> ovf_o=0.
REQ-039 Full with simultaneous pop: FIFO full, valid_i coincident with the lane-3 fire -> write accepted, count_o stays 4, ovf_o stays 0, and the new vector drains last.
REQ-040 Streaming: one valid_i every 4 cycles for 100 vectors, m_ready_i=1 -> no drop, count_o ≤ 1, and output equals input in order.

Source files
------------

// File: rtl/y_drain.sv
// y_drain: buffers whole (h*p) vectors in a small FIFO and drains them one
// DW-bit lane per beat on a valid/ready stream, lanes in ascending order.
//
// Ports
//   clk        single clock, rising edge
//   rstn       asynchronous active-low reset
//   valid_i    y_i valid for one cycle (no backpressure to the source)
//   y_i        N*DW-bit vector, lane k at bits DW*(k+1)-1 : DW*k
//   m_valid_o  output stream valid
//   m_ready_i  output stream ready
//   m_data_o   current lane element (0 while empty)
//   m_lane_o   lane index of m_data_o
//   m_last_o   high on lane N-1 of a vector
//   count_o    vectors stored, partially drained head included
//   full_o     count_o == DEPTH
//   ovf_o      sticky: an input vector was dropped
//   clr_ovf_i  synchronous clear of ovf_o (a same-cycle drop wins)
module y_drain #(
  parameter int unsigned DW     = 16,
  parameter int unsigned H_TILE = 1,
  parameter int unsigned P_TILE = 1,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic                                    valid_i,
  input  logic [H_TILE*P_TILE*DW-1:0]             y_i,
  output logic                                    m_valid_o,
  input  logic                                    m_ready_i,
  output logic [DW-1:0]                           m_data_o,
  output logic [((H_TILE*P_TILE) > 1 ? $clog2(H_TILE*P_TILE) : 1)-1:0] m_lane_o,
  output logic                                    m_last_o,
  output logic [$clog2(DEPTH):0]                  count_o,
  output logic                                    full_o,
  output logic                                    ovf_o,
  input  logic                                    clr_ovf_i
);

  localparam int unsigned N  = H_TILE * P_TILE;
  localparam int unsigned LW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [LW-1:0] LastLane = LW'(N - 1);
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

  // Vector storage; no reset needed, the output mux masks it while empty.
  logic [N*DW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [LW-1:0] lane_q,   lane_d;
  logic          ovf_q,    ovf_d;

  logic          not_empty;
  logic          is_full;
  logic          is_last;
  logic          fire;
  logic          pop;
  logic          wr_en;
  logic          drop;
  logic [N*DW-1:0] head;
  logic [DW-1:0]   lane_data;

  // Handshake decode
  always_comb begin
    not_empty = (count_q != '0);
    is_full   = (count_q == DepthCnt);
    is_last   = (lane_q == LastLane);
    fire      = not_empty && m_ready_i;
    pop       = fire && is_last;
    // A pop frees the head slot at the same edge, so a full FIFO can still accept.
    wr_en     = valid_i && (!is_full || pop);
    drop      = valid_i && is_full && !pop;
  end

  // Next-state logic
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    lane_d   = lane_q;
    ovf_d    = ovf_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (pop) begin
      lane_d = '0;
    end else if (fire) begin
      lane_d = lane_q + 1'b1;
    end

    // Drop takes priority over a same-cycle clear.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      lane_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      lane_q   <= lane_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= y_i;
    end
  end

  // Lane select from the head vector
  always_comb begin
    head      = mem_q[rd_ptr_q];
    lane_data = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (lane_q == LW'(k)) begin
        lane_data = head[k*DW +: DW];
      end
    end
  end

  always_comb begin
    m_valid_o = not_empty;
    m_data_o  = not_empty ? lane_data : '0;
    m_lane_o  = lane_q;
    // Gated by valid so it reads 0 in reset/empty even when N == 1.
    m_last_o  = not_empty && is_last;
    count_o   = count_q;
    full_o    = is_full;
    ovf_o     = ovf_q;
  end

endmodule

// File: tb/tb_y_drain.sv
// Bench for y_drain with H_TILE=2, P_TILE=2, DW=16, DEPTH=4.
// Reference model: a queue of pending output beats; vector count is the
// number of beats left rounded up to whole vectors.
module tb_y_drain;

  localparam int unsigned DW = 16;
  localparam int unsigned NL = 4;

  logic          clk;
  logic          rstn;
  logic          valid_i;
  logic [63:0]   y_i;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [15:0]   m_data_o;
  logic [1:0]    m_lane_o;
  logic          m_last_o;
  logic [2:0]    count_o;
  logic          full_o;
  logic          ovf_o;
  logic          clr_ovf_i;

  y_drain #(
    .DW    (16),
    .H_TILE(2),
    .P_TILE(2),
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .valid_i  (valid_i),
    .y_i      (y_i),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i),
    .m_data_o (m_data_o),
    .m_lane_o (m_lane_o),
    .m_last_o (m_last_o),
    .count_o  (count_o),
    .full_o   (full_o),
    .ovf_o    (ovf_o),
    .clr_ovf_i(clr_ovf_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    int          lane;
  } beat_t;

  beat_t q[$];
  logic  mdl_ovf;
  int    total;
  int    bad;
  string phase;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic        ev;
    logic [15:0] ed;
    int          el;
    int          ec;
    ev = (q.size() != 0);
    ed = ev ? q[0].d : 16'h0;
    el = ev ? q[0].lane : 0;
    ec = (q.size() + NL - 1) / NL;
    chk({phase, "_valid"}, 32'(m_valid_o), 32'(ev));
    chk({phase, "_data"},  32'(m_data_o),  32'(ed));
    chk({phase, "_lane"},  32'(m_lane_o),  32'(el));
    chk({phase, "_last"},  32'(m_last_o),  32'(ev && el == NL - 1));
    chk({phase, "_count"}, 32'(count_o),   32'(ec));
    chk({phase, "_full"},  32'(full_o),    32'(ec == 4));
    chk({phase, "_ovf"},   32'(ovf_o),     32'(mdl_ovf));
  endtask

  // One clock cycle: drive at negedge, check, advance model, wait the posedge.
  task automatic cycle(input logic v, input logic [63:0] y, input logic rdy, input logic clr);
    logic  fire;
    logic  pop;
    logic  full;
    logic  wr;
    beat_t b;
    @(negedge clk);
    valid_i   = v;
    y_i       = y;
    m_ready_i = rdy;
    clr_ovf_i = clr;
    #1;
    check_model();
    fire = (q.size() != 0) && rdy;
    pop  = fire && (q[0].lane == NL - 1);
    full = ((q.size() + NL - 1) / NL) == 4;
    wr   = v && (!full || pop);
    if (fire) void'(q.pop_front());
    if (wr) begin
      for (int k = 0; k < NL; k++) begin
        b.d    = y[16*k +: 16];
        b.lane = k;
        q.push_back(b);
      end
    end
    if (v && !wr) mdl_ovf = 1'b1;
    else if (clr) mdl_ovf = 1'b0;
    @(posedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(m_valid_o), 32'd0);
    chk({tag, "_data"},  32'(m_data_o),  32'd0);
    chk({tag, "_lane"},  32'(m_lane_o),  32'd0);
    chk({tag, "_last"},  32'(m_last_o),  32'd0);
    chk({tag, "_count"}, 32'(count_o),   32'd0);
    chk({tag, "_full"},  32'(full_o),    32'd0);
    chk({tag, "_ovf"},   32'(ovf_o),     32'd0);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic reset_mid();
    #2;
    rstn      = 1'b0;
    valid_i   = 1'b0;
    clr_ovf_i = 1'b0;
    #1;
    check_zero("rst_async");
    q.delete();
    mdl_ovf = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    @(negedge clk);
    rstn = 1'b1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  logic [15:0] tbl [4];
  int          rp [4];

  initial begin
    total     = 0;
    bad       = 0;
    mdl_ovf   = 1'b0;
    rstn      = 1'b0;
    valid_i   = 1'b0;
    y_i       = '0;
    m_ready_i = 1'b0;
    clr_ovf_i = 1'b0;
    tbl[0] = 16'h3C00; tbl[1] = 16'h4000; tbl[2] = 16'h4200; tbl[3] = 16'h4400;
    rp[0] = 1; rp[1] = 0; rp[2] = 0; rp[3] = 1;

    repeat (2) @(negedge clk);
    check_zero("reset");
    rstn = 1'b1;

    // Single vector, ready held high
    phase = "single";
    cycle(1'b1, {16'h4400, 16'h4200, 16'h4000, 16'h3C00}, 1'b1, 1'b0);
    #1;
    chk("single_first_valid", 32'(m_valid_o), 32'd1);
    chk("single_first_data", 32'(m_data_o), 32'(tbl[0]));
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 64'h0, 1'b1, 1'b0);
      #1;
      if (i < 3) begin
        chk("single_beat_data", 32'(m_data_o), 32'(tbl[i+1]));
        chk("single_beat_last", 32'(m_last_o), 32'(i == 2));
      end
    end
    chk("single_end_count", 32'(count_o), 32'd0);
    repeat (2) cycle(1'b0, 64'h0, 1'b1, 1'b0);

    // Backpressure pattern 1,0,0,1
    phase = "bp";
    cycle(1'b1, rnd64(), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 64'h0, 1'(rp[i % 4]), 1'b0);
    repeat (3) cycle(1'b0, 64'h0, 1'b1, 1'b0);

    // Overflow: five writes with no draining
    phase = "ovf";
    for (int i = 0; i < 5; i++) cycle(1'b1, rnd64(), 1'b0, 1'b0);
    #1;
    chk("ovf_count", 32'(count_o), 32'd4);
    chk("ovf_full", 32'(full_o), 32'd1);
    chk("ovf_flag", 32'(ovf_o), 32'd1);
    cycle(1'b1, rnd64(), 1'b0, 1'b1);  // clear and drop together
    #1;
    chk("ovf_clr_vs_drop", 32'(ovf_o), 32'd1);
    for (int i = 0; i < 18; i++) cycle(1'b0, 64'h0, 1'b1, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b1);
    #1;
    chk("ovf_cleared", 32'(ovf_o), 32'd0);

    // Full with a write coinciding with the lane-3 fire
    phase = "fullpop";
    for (int i = 0; i < 4; i++) cycle(1'b1, rnd64(), 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 64'h0, 1'b1, 1'b0);
    cycle(1'b1, rnd64(), 1'b1, 1'b0);
    #1;
    chk("fullpop_count", 32'(count_o), 32'd4);
    chk("fullpop_ovf", 32'(ovf_o), 32'd0);
    chk("fullpop_lane", 32'(m_lane_o), 32'd0);
    repeat (18) cycle(1'b0, 64'h0, 1'b1, 1'b0);

    // Reset in the middle of a partially drained vector
    phase = "midrst";
    cycle(1'b1, rnd64(), 1'b1, 1'b0);
    cycle(1'b1, rnd64(), 1'b1, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0);
    reset_mid();
    phase = "postrst";
    repeat (6) cycle(1'b0, 64'h0, 1'b1, 1'b0);

    // Streaming one vector every four cycles
    phase = "stream";
    for (int i = 0; i < 100; i++) begin
      for (int j = 0; j < 4; j++) begin
        cycle(j == 0, rnd64(), 1'b1, 1'b0);
        #1;
        chk("stream_count_le1", 32'(count_o <= 3'd1), 32'd1);
      end
    end
    repeat (2) cycle(1'b0, 64'h0, 1'b1, 1'b0);

    // Random traffic
    phase = "rand";
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 2) == 0), rnd64(), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0));
    end
    repeat (30) cycle(1'b0, 64'h0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
